// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: three requester holding slots (ex, mem, mdu) share
// one register-file write port. Grants follow a fixed default priority,
// overridden by starvation promotion and by oldest-first ordering for writes
// to the same destination register. A 32-entry scoreboard tracks pending writes.
module wb_port_arbiter #(
   parameter int XLEN       = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [4:0]      ex_waddr,
   input  logic [XLEN-1:0] ex_wdata,
   input  logic [1:0]      ex_ext,
   input  logic            mem_valid,
   output logic            mem_ready,
   input  logic [4:0]      mem_waddr,
   input  logic [XLEN-1:0] mem_wdata,
   input  logic [1:0]      mem_ext,
   input  logic            mdu_valid,
   output logic            mdu_ready,
   input  logic [4:0]      mdu_waddr,
   input  logic [XLEN-1:0] mdu_wdata,
   input  logic [1:0]      mdu_ext,
   output logic            rf_wen,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   output logic [31:0]     busy_mask,
   output logic [2:0]      gnt
);
   localparam logic [3:0] AGE_MAX = 4'(STARVE_MAX);
   // Default-priority rank per slot index (ex=0, mem=1, mdu=2); higher rank wins.
   localparam logic [5:0] RANK = {2'd1, 2'd2, 2'd0};

   // Slot index order everywhere: 0 = ex, 1 = mem, 2 = mdu.
   logic [2:0]      in_valid;
   logic [4:0]      in_waddr [3];
   logic [XLEN-1:0] in_wdata [3];
   logic [1:0]      in_ext   [3];

   logic [2:0]      occ;
   logic [4:0]      waddr [3];
   logic [XLEN-1:0] wdata [3];
   logic [1:0]      ext   [3];
   logic [3:0]      age   [3];

   logic [2:0]      ready;
   logic [2:0]      gnt_vec;
   logic [2:0]      elig;
   logic [2:0]      starved;
   logic [2:0]      pool;
   logic [2:0]      lose [3];

   logic [4:0]      g_waddr;
   logic [XLEN-1:0] g_wdata;
   logic [1:0]      g_ext;
   logic [XLEN-1:0] ext_data;

   logic [31:0]     busy_q, busy_d;

   assign in_valid    = {mdu_valid, mem_valid, ex_valid};
   assign in_waddr[0] = ex_waddr;
   assign in_waddr[1] = mem_waddr;
   assign in_waddr[2] = mdu_waddr;
   assign in_wdata[0] = ex_wdata;
   assign in_wdata[1] = mem_wdata;
   assign in_wdata[2] = mdu_wdata;
   assign in_ext[0]   = ex_ext;
   assign in_ext[1]   = mem_ext;
   assign in_ext[2]   = mdu_ext;

   assign ex_ready  = ready[0];
   assign mem_ready = ready[1];
   assign mdu_ready = ready[2];
   assign gnt       = gnt_vec;

   genvar gi, gj;

   // Holding slots: a slot can be refilled in the same cycle it is granted.
   for (gi = 0; gi < 3; gi++) begin : g_slot
      logic            occ_q, occ_d;
      logic [4:0]      waddr_q, waddr_d;
      logic [XLEN-1:0] wdata_q, wdata_d;
      logic [1:0]      ext_q, ext_d;
      logic [3:0]      age_q, age_d;

      assign ready[gi] = !occ_q || gnt_vec[gi];

      // Load on accept, free on grant, otherwise age (saturating) while waiting.
      always_comb begin
         occ_d   = occ_q;
         waddr_d = waddr_q;
         wdata_d = wdata_q;
         ext_d   = ext_q;
         age_d   = age_q;
         if (in_valid[gi] && ready[gi]) begin
            occ_d   = 1'b1;
            waddr_d = in_waddr[gi];
            wdata_d = in_wdata[gi];
            ext_d   = in_ext[gi];
            age_d   = 4'd0;
         end else if (gnt_vec[gi]) begin
            occ_d = 1'b0;
            age_d = 4'd0;
         end else if (occ_q && age_q < AGE_MAX) begin
            age_d = age_q + 4'd1;
         end
      end

      // Slot state register.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            occ_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ext_q   <= '0;
            age_q   <= '0;
         end else begin
            occ_q   <= occ_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ext_q   <= ext_d;
            age_q   <= age_d;
         end
      end

      assign occ[gi]   = occ_q;
      assign waddr[gi] = waddr_q;
      assign wdata[gi] = wdata_q;
      assign ext[gi]   = ext_q;
      assign age[gi]   = age_q;
   end

   // Same-destination ordering: slot gi yields to slot gj if gj is older,
   // or equally old with higher default rank. This keeps register writes in order.
   for (gi = 0; gi < 3; gi++) begin : g_pair
      for (gj = 0; gj < 3; gj++) begin : g_col
         if (gi == gj) begin : g_self
            assign lose[gi][gj] = 1'b0;
         end else begin : g_other
            assign lose[gi][gj] = occ[gj] && (waddr[gi] == waddr[gj]) &&
                                  ((age[gj] > age[gi]) ||
                                   ((age[gj] == age[gi]) &&
                                    (RANK[2*gj +: 2] > RANK[2*gi +: 2])));
         end
      end
      assign elig[gi]    = occ[gi] && !(|lose[gi]);
      assign starved[gi] = elig[gi] && (age[gi] == AGE_MAX);
   end

   // Pick one winner: starved slots first, then default order mem > mdu > ex.
   always_comb begin
      pool    = (|starved) ? starved : elig;
      gnt_vec = 3'b000;
      if (pool[1])      gnt_vec = 3'b010;
      else if (pool[2]) gnt_vec = 3'b100;
      else if (pool[0]) gnt_vec = 3'b001;
   end

   // Route the granted slot to the write port; all zero when idle.
   always_comb begin
      g_waddr = '0;
      g_wdata = '0;
      g_ext   = '0;
      case (gnt_vec)
         3'b001:  begin g_waddr = waddr[0]; g_wdata = wdata[0]; g_ext = ext[0]; end
         3'b010:  begin g_waddr = waddr[1]; g_wdata = wdata[1]; g_ext = ext[1]; end
         3'b100:  begin g_waddr = waddr[2]; g_wdata = wdata[2]; g_ext = ext[2]; end
         default: ;
      endcase
   end

   // Sign/zero extension of the written value.
   always_comb begin
      case (g_ext)
         2'd1:    ext_data = {{(XLEN-32){g_wdata[31]}}, g_wdata[31:0]};
         2'd2:    ext_data = {{(XLEN-32){1'b0}}, g_wdata[31:0]};
         2'd3:    ext_data = {{(XLEN-16){g_wdata[15]}}, g_wdata[15:0]};
         default: ext_data = g_wdata;
      endcase
   end

   // x0 writes consume a grant but never reach the register file.
   assign rf_wen   = (|gnt_vec) && (g_waddr != 5'd0);
   assign rf_waddr = g_waddr;
   assign rf_wdata = ext_data;

   // Scoreboard next state: retire clears, issue sets, issue wins on collision.
   always_comb begin
      busy_d = busy_q;
      if (rf_wen) busy_d[rf_waddr] = 1'b0;
      if (iss_valid && iss_rd != 5'd0) busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_mask = busy_q;
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter XLEN, 64, register data width.
REQ-002 Parameter STARVE_MAX, 4, wait cycles after which a slot gets forced priority; range 1..15.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Requester ports for r in {ex, mem, mdu}: r_valid in 1; r_ready out 1; r_waddr in 5; r_wdata in XLEN; r_ext in 2 (0 pass, 1 sext32, 2 zext32, 3 sext16).
REQ-006 rf_wen  out  1  register-file write enable.
REQ-007 rf_waddr  out  5  register-file write address.
REQ-008 rf_wdata  out  XLEN  extended write data.
REQ-009 iss_valid  in  1  decode issues an instruction writing iss_rd.
REQ-010 iss_rd  in  5  destination register of the issued instruction.
REQ-011 busy_mask  out  32  scoreboard; bit k=1 means xk has a pending write.
REQ-012 gnt  out  3  one-hot grant this cycle {mdu, mem, ex}; all-zero when idle.

Function
REQ-013 Each requester owns one holding slot {occ, waddr, wdata, ext, age[3:0]}.
REQ-014 r_ready = !occ | gnt_r, same cycle; a slot accepts one request per cycle.
REQ-015 On r_valid & r_ready, fields load at the edge, occ=1, age=0; inputs never reach rf_* combinationally.
REQ-016 Arbitration runs over occupied slots each cycle; exactly one grant when any slot is occupied.
REQ-017 Default priority: mem > mdu > ex.
REQ-018 Any slot with age == STARVE_MAX wins over default priority; among several, default priority decides.
REQ-019 Two occupied slots with equal waddr: the larger age wins, overriding REQ-017/018; equal age resolved by default priority.
REQ-020 Granted slot clears occ at the edge unless refilled in the same cycle (REQ-014), in which case it reloads with age 0.
REQ-021 Every occupied, non-granted slot increments age per cycle, saturating at STARVE_MAX.
REQ-022 Latency: request accepted at edge ending cycle N -> earliest rf_wen in cycle N+1.
REQ-023 rf_wen = granted & (waddr != 0); x0 writes are granted and consume the slot but never assert rf_wen.
REQ-024 rf_wdata from ext: 0 wdata; 1 {32{wdata[31]}, wdata[31:0]}; 2 {32'b0, wdata[31:0]}; 3 {48{wdata[15]}, wdata[15:0]}.
REQ-025 When idle, rf_wen=0 and rf_waddr=0, rf_wdata=0.
REQ-026 Scoreboard: iss_valid & iss_rd!=0 sets busy_mask[iss_rd]; rf_wen clears busy_mask[rf_waddr].
REQ-027 Set and clear of the same bit in one cycle: set wins.
REQ-028 busy_mask[0] is constant 0.
REQ-029 Throughput: one register write per cycle sustained; with all three slots full, each drains within 3 cycles.

Reset
REQ-030 While rst_n=0: all occ=0, age=0, busy_mask=0, gnt=0, rf_wen=0, rf_waddr=0, rf_wdata=0, all r_ready=1.
REQ-031 Reset mid-operation discards all slot contents and scoreboard bits immediately; no write issues after release until new requests are accepted.

Verification
REQ-032 ex, mem, mdu all valid in cycle 0 (waddr 5, 6, 7) -> gnt mem, then mdu, then ex in cycles 1, 2, 3; rf_waddr 6, 7, 5.
REQ-033 mem_valid every cycle, ex held occupied, STARVE_MAX=4 -> ex granted no later than its 5th waiting cycle; mem_ready low that cycle only.
REQ-034 mdu (waddr 9, age 2) and mem (waddr 9, age 0) both occupied -> mdu granted first, final x9 = mdu data.
REQ-035 mem_wdata=0x0000_0000_8000_1234: ext=1 -> 0xFFFF_FFFF_8000_1234; ext=2 -> 0x0000_0000_8000_1234; ext=3 -> 0x0000_0000_0000_1234.
REQ-036 ex request waddr 0 -> ex granted, rf_wen=0, slot freed; iss_rd=3 issued the same cycle rf_wen clears x3 -> busy_mask[3]=1.
REQ-037 Assert rst_n=0 with all slots full -> next cycle rf_wen=0, busy_mask=0, all ready=1.
